// File: rtl/adder_share_arbiter.sv
// Two requesters share one 16-bit adder through a round-robin grant.
// The sum is registered and held under a valid/ready handshake.

module Adder_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Sum,
  output logic        Cout
);
  assign {Cout, Sum} = {1'b0, A} + {1'b0, B};
endmodule

// state | meaning
// IDLE  | no result held
// HOLD  | result held, ResValid=1
module adder_share_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req0Valid,
  input  logic [WIDTH-1:0] Req0A,
  input  logic [WIDTH-1:0] Req0B,
  output logic             Req0Ready,
  input  logic             Req1Valid,
  input  logic [WIDTH-1:0] Req1A,
  input  logic [WIDTH-1:0] Req1B,
  output logic             Req1Ready,
  output logic             ResValid,
  input  logic             ResReady,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             ResId,
  output logic [15:0]      OpCount
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             id_q, id_d;
  logic [15:0]      op_count_q, op_count_d;

  logic             free;
  logic             grant0, grant1, xfer;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cout;

  Adder_16bit u_adder (
    .A    (add_a),
    .B    (add_b),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      id_q       <= 1'b0;
      op_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      id_q       <= id_d;
      op_count_q <= op_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    result_d   = result_q;
    carry_d    = carry_q;
    id_d       = id_q;
    op_count_d = op_count_q;
    add_a      = grant1 ? Req1A : Req0A;
    add_b      = grant1 ? Req1B : Req0B;

    if (xfer) begin
      state_d  = HOLD;
      prio_d   = grant0;
      result_d = add_sum;
      carry_d  = add_cout;
      id_d     = grant1;
    end else if (state_q == HOLD && ResReady) begin
      state_d = IDLE;
    end

    if (state_q == HOLD && ResReady)
      op_count_d = op_count_q + 16'd1;
  end

  // Ready is gated by Reset so nothing can appear granted while state is being cleared.
  always_comb begin
    free      = (state_q == IDLE) || ResReady;
    grant0    = !Reset && free && Req0Valid && (!Req1Valid || !prio_q);
    grant1    = !Reset && free && Req1Valid && (!Req0Valid ||  prio_q);
    xfer      = grant0 || grant1;
    Req0Ready = grant0;
    Req1Ready = grant1;
    ResValid  = (state_q == HOLD);
    Result    = result_q;
    CarryOut  = carry_q;
    ResId     = id_q;
    OpCount   = op_count_q;
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench: stimulus pushes expected {id,carry,sum} on each grant,
// a negedge monitor pops and compares on every accepted result.

module tb_adder_share_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Req0Valid, Req1Valid, ResReady;
  logic [15:0] Req0A, Req0B, Req1A, Req1B;
  logic        Req0Ready, Req1Ready, ResValid, CarryOut, ResId;
  logic [15:0] Result, OpCount;

  int vectors = 0;
  int errors  = 0;
  logic [17:0] sb[$];

  adder_share_arbiter #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0Valid(Req0Valid), .Req0A(Req0A), .Req0B(Req0B), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1A(Req1A), .Req1B(Req1B), .Req1Ready(Req1Ready),
    .ResValid(ResValid), .ResReady(ResReady), .Result(Result),
    .CarryOut(CarryOut), .ResId(ResId), .OpCount(OpCount)
  );

  always #5 Clock = ~Clock;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Drive one cycle; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                      input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                      input logic rr, input logic er0, input logic er1);
    Req0Valid = v0; Req0A = a0; Req0B = b0;
    Req1Valid = v1; Req1A = a1; Req1B = b1;
    ResReady  = rr;
    @(negedge Clock);
    chk("req0_ready", {31'd0, Req0Ready}, {31'd0, er0});
    chk("req1_ready", {31'd0, Req1Ready}, {31'd0, er1});
    if (er0) sb.push_back({1'b0, {1'b0, a0} + {1'b0, b0}});
    if (er1) sb.push_back({1'b1, {1'b0, a1} + {1'b0, b1}});
    @(posedge Clock);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge Clock);
      if (!Reset && ResValid && ResReady) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", {14'd0, ResId, CarryOut, Result}, 32'hDEAD);
        end else begin
          logic [17:0] e;
          e = sb.pop_front();
          chk("result", {14'd0, ResId, CarryOut, Result}, {14'd0, e});
        end
      end
    end
  end

  initial begin
    Reset = 1'b1;
    Req0Valid = 1'b1; Req0A = 16'd0; Req0B = 16'd0;
    Req1Valid = 1'b1; Req1A = 16'd0; Req1B = 16'd0;
    ResReady = 1'b1;
    @(posedge Clock);
    #1;
    chk("rst_req0_ready", {31'd0, Req0Ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, Req1Ready}, 32'd0);
    chk("rst_outputs", {13'd0, ResValid, ResId, CarryOut, Result}, 32'd0);
    chk("rst_opcount", {16'd0, OpCount}, 32'd0);
    Reset = 1'b0;

    // 5+5 from req0, accepted next cycle
    step(1, 16'd5, 16'd5, 0, 16'd0, 16'd0, 1, 1, 0);
    chk("first_valid", {31'd0, ResValid}, 32'd1);
    chk("first_sum", {16'd0, Result}, 32'd10);
    step(0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 1, 0, 0);
    chk("opcount_1", {16'd0, OpCount}, 32'd1);
    chk("idle_valid", {31'd0, ResValid}, 32'd0);

    // req1 carry-out case, then ordinary sum back to back
    step(0, 16'd0, 16'd0, 1, 16'hFFFF, 16'h0001, 1, 0, 1);
    chk("carry_set", {31'd0, CarryOut}, 32'd1);
    step(0, 16'd0, 16'd0, 1, 16'd756, 16'd862, 1, 0, 1);

    // both valid: grants alternate 0,1,0,1
    step(1, 16'd6, 16'd3, 1, 16'd205, 16'd192, 1, 1, 0);
    step(1, 16'd6, 16'd3, 1, 16'd205, 16'd192, 1, 0, 1);
    step(1, 16'd6, 16'd3, 1, 16'd205, 16'd192, 1, 1, 0);
    step(1, 16'd6, 16'd3, 1, 16'd205, 16'd192, 1, 0, 1);

    // consumer stalls with 397 pending
    for (int i = 0; i < 3; i++) begin
      step(1, 16'd6, 16'd3, 0, 16'd0, 16'd0, 0, 0, 0);
      chk("stall_valid", {31'd0, ResValid}, 32'd1);
      chk("stall_sum", {16'd0, Result}, 32'd397);
    end
    step(1, 16'd6, 16'd3, 0, 16'd0, 16'd0, 1, 1, 0);
    step(0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 1, 0, 0);
    chk("opcount_8", {16'd0, OpCount}, 32'd8);

    // async reset while holding an unaccepted result
    step(1, 16'd1, 16'd2, 0, 16'd0, 16'd0, 0, 1, 0);
    step(0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 0, 0, 0);
    #2;
    Reset = 1'b1;
    #1;
    sb.delete();
    chk("async_rst_outputs", {13'd0, ResValid, ResId, CarryOut, Result}, 32'd0);
    chk("async_rst_opcount", {16'd0, OpCount}, 32'd0);
    Req0Valid = 1'b1; Req1Valid = 1'b1; ResReady = 1'b1;
    #1;
    chk("rst_hold_ready", {30'd0, Req1Ready, Req0Ready}, 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    step(1, 16'd7, 16'd8, 1, 16'd9, 16'd10, 1, 1, 0);
    step(0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 1, 0, 0);
    chk("post_rst_opcount", {16'd0, OpCount}, 32'd1);

    // OpCount wrap
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    step(1, 16'd100, 16'd200, 0, 16'd0, 16'd0, 1, 1, 0);
    step(0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 1, 0, 0);
    chk("opcount_wrap", {16'd0, OpCount}, 32'd0);

    repeat (2) @(posedge Clock);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
